// File: rtl/present_dec_keyperm_stage.sv
// rtl/present_dec_keyperm_stage.sv - PRESENT decrypt round front-end: key removal, inverse permutation, 2-entry skid buffer.
// Optional out_parity port enabled by DEC_OUT_PARITY_EN.
module present_dec_keyperm_stage #(
  parameter int DATA_W  = 64,
  parameter int ROUND_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [DATA_W-1:0]  in_key,
  input  logic [ROUND_W-1:0] in_round,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [ROUND_W-1:0] out_round,
  output logic               out_last,
`ifdef DEC_OUT_PARITY_EN
  output logic               out_parity,
`endif
  output logic               round_err
);

  logic [DATA_W-1:0]  data_q  [2];
  logic [ROUND_W-1:0] round_q [2];
`ifdef DEC_OUT_PARITY_EN
  logic               parity_q [2];
`endif
  logic               rd_ptr_q, wr_ptr_q;
  logic [1:0]         count_q, count_d;
  logic               round_err_q, round_err_d;

  logic [DATA_W-1:0]  key_x;
  logic [DATA_W-1:0]  perm_x;
  logic               accept, launch;

  assign key_x = in_data ^ in_key;

  // Output bit j takes x[16*j mod 63]; the top bit maps to itself.
  always_comb begin
    perm_x = '0;
    for (int j = 0; j < DATA_W - 1; j++) begin
      perm_x[j] = key_x[(16 * j) % (DATA_W - 1)];
    end
    perm_x[DATA_W-1] = key_x[DATA_W-1];
  end

  assign in_ready  = (count_q != 2'd2) & ~rst;
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid & in_ready;
  assign launch    = out_valid & out_ready;

  assign out_data  = data_q[rd_ptr_q];
  assign out_round = round_q[rd_ptr_q];
  assign out_last  = (round_q[rd_ptr_q] == ROUND_W'(1));
  assign round_err = round_err_q;
`ifdef DEC_OUT_PARITY_EN
  assign out_parity = parity_q[rd_ptr_q];
`endif

  always_comb begin
    count_d = count_q;
    case ({accept, launch})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    round_err_d = round_err_q | (accept & (in_round == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i]   <= '0;
        round_q[i]  <= '0;
`ifdef DEC_OUT_PARITY_EN
        parity_q[i] <= 1'b0;
`endif
      end
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      round_err_q <= 1'b0;
    end else begin
      if (accept) begin
        data_q[wr_ptr_q]   <= perm_x;
        round_q[wr_ptr_q]  <= in_round;
`ifdef DEC_OUT_PARITY_EN
        parity_q[wr_ptr_q] <= ^perm_x;
`endif
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (launch) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q     <= count_d;
      round_err_q <= round_err_d;
    end
  end

endmodule
